// File: rtl/heard_ind_serializer_pkg.sv
// Shared types and header layout for the heard indication serializer.
package heard_ind_serializer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StMeth,
    StVal
  } state_e;

  // Header word layout: method id in the upper half, payload word count below.
  localparam int unsigned HdrIdMsb  = 31;
  localparam int unsigned HdrIdLsb  = 16;
  localparam int unsigned HdrLenMsb = 15;
  localparam int unsigned HdrLenLsb = 0;

  localparam logic [15:0] DefaultMethodId = 16'h0001;

  function automatic logic [31:0] hdr_word(input logic [15:0] id, input logic [15:0] len);
    logic [31:0] word;
    word                      = '0;
    word[HdrIdMsb:HdrIdLsb]   = id;
    word[HdrLenMsb:HdrLenLsb] = len;
    return word;
  endfunction

endpackage

// File: rtl/heard_ind_serializer.sv
// Serializes one heard(meth, v) indication into header + meth words + v words,
// holding one message at a time and back-pressuring the producer.
module heard_ind_serializer
  import heard_ind_serializer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 192,
  parameter int unsigned WORD_WIDTH = 32,
  parameter logic [15:0] METHOD_ID  = DefaultMethodId
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  heard__ENA,
  input  logic [DATA_WIDTH-1:0] heard_meth,
  input  logic [DATA_WIDTH-1:0] heard_v,
  output logic                  heard__RDY,
  output logic                  out__ENA,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out__RDY,
  output logic [15:0]           msg_count
);

  localparam int unsigned NW   = DATA_WIDTH / WORD_WIDTH;
  localparam int unsigned IdxW = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned OffW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NW - 1);
  localparam logic [WORD_WIDTH-1:0] HdrWord = WORD_WIDTH'(hdr_word(METHOD_ID, 16'(2 * NW)));

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] meth_q, meth_d;
  logic [DATA_WIDTH-1:0] v_q, v_d;
  logic [15:0]           msg_count_q, msg_count_d;

  logic            last_word;
  logic            accept;
  logic [OffW-1:0] word_off;

  assign last_word  = (state_q == StVal) && (idx_q == IdxLast);
  assign out__ENA   = (state_q != StIdle) & out__RDY;
  // Ready while the last word leaves so back-to-back messages have no bubble.
  assign heard__RDY = (state_q == StIdle) | (last_word & out__RDY);
  // A fire while not ready is a protocol violation and is dropped here.
  assign accept     = heard__ENA & heard__RDY;
  assign word_off   = OffW'(idx_q) * OffW'(WORD_WIDTH);
  assign msg_count  = msg_count_q;
  assign out_last   = last_word;

  // Output word mux: sliced directly from the captured argument registers.
  always_comb begin
    out_data = '0;
    unique case (state_q)
      StIdle:  out_data = '0;
      StHdr:   out_data = HdrWord;
      StMeth:  out_data = meth_q[word_off +: WORD_WIDTH];
      StVal:   out_data = v_q[word_off +: WORD_WIDTH];
      default: out_data = '0;
    endcase
  end

  // Next-state: capture on accept, advance the word index on each transfer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    meth_d      = meth_q;
    v_d         = v_q;
    msg_count_d = msg_count_q;
    if (accept) begin
      meth_d = heard_meth;
      v_d    = heard_v;
    end
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StHdr;
      end
      StHdr: begin
        if (out__ENA) begin
          state_d = StMeth;
          idx_d   = '0;
        end
      end
      StMeth: begin
        if (out__ENA) begin
          if (idx_q == IdxLast) begin
            state_d = StVal;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StVal: begin
        if (out__ENA) begin
          if (idx_q == IdxLast) begin
            msg_count_d = msg_count_q + 16'd1;
            idx_d       = '0;
            state_d     = accept ? StHdr : StIdle;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      meth_q      <= '0;
      v_q         <= '0;
      msg_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      meth_q      <= meth_d;
      v_q         <= v_d;
      msg_count_q <= msg_count_d;
    end
  end

endmodule

// File: tb/tb_heard_ind_serializer.sv
// Randomized bench for heard_ind_serializer against a queue-based message model.
module tb_heard_ind_serializer;

  localparam int unsigned DW = 192;
  localparam int unsigned WW = 32;
  localparam int unsigned NW = DW / WW;

  logic          CLK;
  logic          nRST;
  logic          heard__ENA;
  logic [DW-1:0] heard_meth;
  logic [DW-1:0] heard_v;
  logic          heard__RDY;
  logic          out__ENA;
  logic [WW-1:0] out_data;
  logic          out_last;
  logic          out__RDY;
  logic [15:0]   msg_count;

  heard_ind_serializer dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .heard__ENA (heard__ENA),
    .heard_meth (heard_meth),
    .heard_v    (heard_v),
    .heard__RDY (heard__RDY),
    .out__ENA   (out__ENA),
    .out_data   (out_data),
    .out_last   (out_last),
    .out__RDY   (out__RDY),
    .msg_count  (msg_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } word_t;

  word_t       exp_q[$];
  logic [15:0] exp_count;
  int          n_checks;
  int          n_pass;
  int          viol_cnt;

  // Protocol monitor: counts fires presented while the block is not ready.
  always @(posedge CLK) begin
    if (nRST && heard__ENA && !heard__RDY) viol_cnt <= viol_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [DW-1:0] rand_arg();
    logic [DW-1:0] r;
    for (int i = 0; i < int'(NW); i++) r[i*WW +: WW] = $urandom;
    return r;
  endfunction

  function automatic logic model_rdy(input logic rdy);
    return (exp_q.size() == 0) || (exp_q.size() == 1 && rdy);
  endfunction

  // A message is a header (id 1, length 2*NW), meth words then v words, LSW first.
  task automatic push_msg(input logic [DW-1:0] m, input logic [DW-1:0] v);
    word_t w;
    w.data = 32'h0001_000C;
    w.last = 1'b0;
    exp_q.push_back(w);
    for (int i = 0; i < int'(NW); i++) begin
      w.data = m[i*WW +: WW];
      w.last = 1'b0;
      exp_q.push_back(w);
    end
    for (int i = 0; i < int'(NW); i++) begin
      w.data = v[i*WW +: WW];
      w.last = (i == int'(NW) - 1);
      exp_q.push_back(w);
    end
  endtask

  // One clock cycle: drive at negedge, check settled outputs, update model, advance.
  task automatic step(input logic rn, input logic ena, input logic [DW-1:0] m,
                      input logic [DW-1:0] v, input logic rdy);
    logic exp_rdy;
    logic exp_ena;
    nRST       = rn;
    heard__ENA = ena;
    heard_meth = m;
    heard_v    = v;
    out__RDY   = rdy;
    #1;
    if (rn) begin
      exp_rdy = model_rdy(rdy);
      exp_ena = (exp_q.size() != 0) && rdy;
      check_eq("heard_rdy", {31'd0, heard__RDY}, {31'd0, exp_rdy});
      check_eq("out_ena", {31'd0, out__ENA}, {31'd0, exp_ena});
      check_eq("msg_count", {16'd0, msg_count}, {16'd0, exp_count});
      if (exp_q.size() == 0) begin
        check_eq("idle_data", out_data, 32'd0);
        check_eq("idle_last", {31'd0, out_last}, 32'd0);
      end else begin
        check_eq("out_data", out_data, exp_q[0].data);
        check_eq("out_last", {31'd0, out_last}, {31'd0, exp_q[0].last});
      end
      if (exp_ena) begin
        if (exp_q[0].last) exp_count = exp_count + 16'd1;
        void'(exp_q.pop_front());
      end
      if (ena && exp_rdy) push_msg(m, v);
    end else begin
      exp_q.delete();
      exp_count = '0;
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // mode 0: sink always ready, 1: ready every third cycle, 2: random ready and fires.
  task automatic run(input int cycles, input int msgs, input int mode);
    int   sent;
    logic rdy;
    logic ena;
    sent = 0;
    for (int c = 0; c < cycles; c++) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (c % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ena = (sent < msgs) && model_rdy(rdy) && (mode != 2 || $urandom_range(0, 1) == 1);
      if (ena) sent++;
      step(1'b1, ena, rand_arg(), rand_arg(), rdy);
    end
  endtask

  initial begin
    logic [DW-1:0] m1;
    logic [DW-1:0] v1;
    int            viol_before;
    n_checks   = 0;
    n_pass     = 0;
    viol_cnt   = 0;
    exp_count  = '0;
    nRST       = 1'b0;
    heard__ENA = 1'b0;
    heard_meth = '0;
    heard_v    = '0;
    out__RDY   = 1'b0;

    step(1'b0, 1'b0, '0, '0, 1'b1);
    step(1'b0, 1'b0, '0, '0, 1'b1);

    // Single message, fixed pattern, sink always ready.
    m1 = 192'h0605040302010;
    v1 = '1;
    step(1'b1, 1'b1, m1, v1, 1'b1);
    run(15, 0, 0);
    check_eq("count_single", {16'd0, msg_count}, 32'd1);

    // Back-to-back pair.
    run(30, 2, 0);
    check_eq("count_b2b", {16'd0, msg_count}, 32'd3);

    // Backpressure.
    run(50, 1, 1);
    run(5, 0, 0);

    // Reset while the fifth word (meth word 3) is presented.
    step(1'b1, 1'b1, rand_arg(), rand_arg(), 1'b1);
    run(4, 0, 0);
    step(1'b0, 1'b0, '0, '0, 1'b1);
    step(1'b1, 1'b0, '0, '0, 1'b1);
    check_eq("count_after_rst", {16'd0, msg_count}, 32'd0);
    run(16, 1, 0);

    // Counter wrap.
    force dut.msg_count_q = 16'hFFFF;
    @(posedge CLK);
    @(negedge CLK);
    release dut.msg_count_q;
    exp_count = 16'hFFFF;
    run(16, 1, 0);
    check_eq("count_wrap", {16'd0, msg_count}, 32'd0);

    // Fire while busy must be ignored and flagged by the monitor.
    m1 = rand_arg();
    v1 = rand_arg();
    step(1'b1, 1'b1, m1, v1, 1'b1);
    run(3, 0, 0);
    viol_before = viol_cnt;
    step(1'b1, 1'b1, ~m1, ~v1, 1'b1);
    check_eq("protocol_mon", viol_cnt, viol_before + 1);
    run(12, 0, 0);

    // Random traffic and backpressure, then drain.
    run(400, 1000, 2);
    run(30, 0, 0);
    check_eq("drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/heard_ind_serializer.md
Name: heard_ind_serializer

Overview:
- Downstream stage of the say/respond connect block: consumes its heard(meth, v) indication method and serializes it into a 32-bit word stream toward the host indication portal.
- Each message is one header word, the meth words, then the v words, with out_last marking the final word.
- Holds one message at a time and back-pressures heard via heard__RDY.

Parameters:
- DATA_WIDTH, 192, width of each of meth and v. Must be a multiple of WORD_WIDTH.
- WORD_WIDTH, 32, output word width.
- METHOD_ID, 16'h0001, method identifier placed in header bits [31:16].
- Derived constant NW = DATA_WIDTH/WORD_WIDTH (6 at defaults).

Ports:
- CLK  input  1  clock
- nRST  input  1  reset, synchronous, active-low
- heard__ENA  input  1  indication fire; asserted only while heard__RDY=1
- heard_meth  input  DATA_WIDTH  meth argument
- heard_v  input  DATA_WIDTH  v argument
- heard__RDY  output  1  block can accept a message this cycle
- out__ENA  output  1  word transferred this cycle (= word valid & out__RDY)
- out_data  output  WORD_WIDTH  current word
- out_last  output  1  current word is the last word of the message
- out__RDY  input  1  sink can take a word this cycle
- msg_count  output  16  count of completed messages

Behaviour:
- Reset (synchronous, nRST=0 at a CLK edge): state=IDLE, word index=0, msg_count=0, captured meth/v registers=0.
  - Resulting outputs: out__ENA=0, out_data=0, out_last=0, heard__RDY=1 in the first cycle after reset.
- Reset mid-message: the partial message is discarded silently. No out_last is emitted and msg_count does not increment.
- States: IDLE, HDR, METH, VAL.
- IDLE:
  - heard__RDY=1.
  - On heard__ENA, capture meth and v into registers and go to HDR next cycle.
  - Latency from heard__ENA to the first valid header word: 1 cycle.
- HDR:
  - Word valid; out_data = {METHOD_ID, 16'(2*NW)}, i.e. 0x0001_000C at defaults.
  - On transfer (out__ENA): go to METH, idx=0.
- METH:
  - out_data = meth[idx*WORD_WIDTH +: WORD_WIDTH]; least-significant word first.
  - On transfer: idx++. When idx==NW-1, go to VAL with idx=0.
- VAL:
  - out_data = v[idx*WORD_WIDTH +: WORD_WIDTH].
  - out_last=1 when idx==NW-1.
  - On transfer of the last word: msg_count++ (wraps 0xFFFF -> 0x0000).
  - Next state after the last word: IDLE, or HDR if a new message is accepted in the same cycle.
- heard__RDY:
  - Equals (state==IDLE) | (state==VAL & idx==NW-1 & out__RDY).
  - This lets a new message be captured in the same cycle the last word leaves: 1+2*NW = 13 cycles per message back-to-back.
  - heard__RDY is combinationally dependent on out__RDY.
- out__ENA = (state!=IDLE) & out__RDY. The word register holds stable while out__RDY=0; no word is lost or duplicated under stall.
- In IDLE: out_data=0 and out_last=0.
- out_last is meaningful only while state==VAL; it is 0 elsewhere.
- heard__ENA while heard__RDY=0 is a protocol violation:
  - The block ignores it; captured data is unchanged.
  - The verification bench asserts on it.
- All arithmetic is unsigned. The index is a clog2(NW)-bit counter, never exceeds NW-1, and has no wrap inside a field.

Decomposition:
- Shared package holds:
  - state enum {IDLE, HDR, METH, VAL}
  - header layout constants: ID field [31:16], length field [15:0]
  - default METHOD_ID
- No sub-module is needed. The word mux is a sliced shift from the captured registers, done inline.

Test Plan:
- Single message with out__RDY held at 1: meth=192'h0…0605040302010, v=all bits set.
  - Expect 13 consecutive out__ENA words: 0x0001000C, then meth words LSB first, then six 0xFFFFFFFF.
  - out_last on word 13; msg_count=1.
- Back-to-back: two messages with heard__ENA on the accept cycle of each last word.
  - Expect 26 contiguous out__ENA cycles and heard__RDY=1 on cycles 13 and 26.
  - msg_count=2.
- Backpressure: out__RDY toggles 1,0,0,1,… during a message.
  - out_data is held while stalled; the word sequence is identical to the first scenario.
  - heard__RDY=0 throughout except the IDLE/last-word condition.
- Reset mid-message: nRST=0 on word 5 (meth word 4).
  - Next cycle: state IDLE, out__ENA=0, msg_count unchanged (0).
  - A following message serializes correctly from its header.
- Counter wrap: preload via 65535 messages (or force msg_count=16'hFFFF), then send one message. msg_count=0x0000 after its out_last.
- Protocol check: drive heard__ENA while state==METH.
  - Captured data is unchanged; output words match the original message.
  - The bench assertion fires.
